jk_stim_sequencer: RTL and testbench
====================================

// Module: jk_stim_sequencer
// PURPOSE
//  Drive side of the JK flip-flop interface. Loads a LEN-bit target q pattern and computes the JK excitation for each step.
//  Drives j/k into an external JK flip-flop clocked on the same c, and checks its q feedback.
//  Used as a self-checking stimulus engine in the lab flip-flop benches and in small sequential datapaths.
// PARAMETERS
//  LEN   8  pattern length in steps; bit 0 is applied first
//  CNTW  4  mismatch counter width (only used when JKSEQ_MISCNT_EN is defined)
// PORTS
//  c        in   1            clock, rising edge
//  rst_n    in   1            asynchronous active-low reset
//  start    in   1            run request; sampled only in IDLE
//  pattern  in   LEN          target q sequence; latched on accepted start
//  pol      in   1            don't-care policy: 0 = prefer hold/set/reset, 1 = prefer toggle; latched on start
//  q_fb     in   1            q from the driven JK flip-flop
//  j, k     out  1            registered JK drive
//  busy     out  1            high from accepted start until done
//  done     out  1            one-cycle completion pulse
//  err      out  1            sticky mismatch flag; cleared on accepted start
//  idx      out  $clog2(LEN)  index of the step being driven; 0 outside RUN
//  mis_cnt  out  CNTW         mismatch count; port present only with JKSEQ_MISCNT_EN
// BEHAVIOUR
//  Reset (async, immediate, also mid-run): j=0, k=0, busy=0, done=0, err=0, idx=0, mis_cnt=0, state=IDLE.
//  States: IDLE -> RUN (LEN cycles) -> DRAIN (2 cycles) -> DONE (1 cycle) -> IDLE.
//  Edge E0, IDLE with start=1:
//   - latch pattern and pol; cur = q_fb.
//   - register step 0's j/k; set busy=1, err=0, mis_cnt=0.
//  Step i (0..LEN-1):
//   - j/k registered at edge E0+i from cur -> t = pattern[i]; then cur <= t.
//   - cur tracks the expected state, never q_fb, so a faulty flip-flop does not cascade.
//  Excitation as (j,k), pol=0 / pol=1:
//   - 0->0: 00 / 01
//   - 0->1: 10 / 11
//   - 1->0: 01 / 11
//   - 1->1: 00 / 10
//  Check:
//   - The flip-flop captures step i at E0+i+1.
//   - q_fb is compared with pattern[i] at edge E0+i+2 through a 2-deep expected-value pipeline.
//   - On mismatch, err <= 1.
//  Sequence timing:
//   - j,k return to 00 (hold) at edge E0+LEN.
//   - Last check is at E0+LEN+1.
//   - done=1 and busy=0 at E0+LEN+2; done clears the next edge.
//  start while busy or in DONE: ignored, not queued. A new start is accepted the first cycle back in IDLE.
//  LEN=1 is legal: RUN lasts one cycle.
// CONFIGURATION
//  JKSEQ_MISCNT_EN defined:
//   - Adds mis_cnt, which increments on each mismatched check.
//   - Saturates at 2**CNTW-1; cleared on accepted start and on reset.
//  JKSEQ_MISCNT_EN undefined:
//   - No mis_cnt port or counter logic; err is the only fault indication.
// STRUCTURE
//  Package jkseq_pkg:
//   - state enum {IDLE, RUN, DRAIN, DONE}.
//   - JK command constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
//  Sub-module jk_excite: combinational (cur, t, pol) -> {j,k}. Instantiated once; also reused by the bench model.
//  Top holds the FSM, step counter, pattern shadow, expected pipeline, err and mis_cnt.
// TESTING (LEN=8; behavioural JK model on c, q initially 0; pattern bit0 first)
//  1. Directed sequence, pattern=8'b1011_0010, pol=0:
//     -> j,k per step = 00,10,01,00,10,00,01,10; err=0; done at E0+10.
//  2. Same pattern, pol=1:
//     -> j,k = 01,11,11,01,11,10,11,11; q follows the pattern; err=0.
//  3. Model q stuck at 0, pattern=8'hFF:
//     -> err=1 from E0+2; with macro, mis_cnt=8 at done.
//  4. CNTW=2, macro on, stuck-at-0 fault, 8'hFF:
//     -> mis_cnt saturates at 3; no wrap.
//  5. Start handling:
//     -> start held high across a run: second run accepted one cycle after done.
//     -> start pulses during busy are ignored.
//  6. rst_n low at step 4:
//     -> j=k=0, busy=0, done=0, err=0 immediately; no done pulse after release.

Source files
------------

// File: rtl/jkseq_pkg.sv
// Shared types and constants for the JK stimulus sequencer.
//   state_t : sequencer FSM states
//   JK_*    : {j,k} command encodings driven to the flip-flop
package jkseq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_excite.sv
// JK excitation: which {j,k} moves a JK flip-flop from cur to t.
// Where j or k is a don't-care, pol picks the filler:
//   pol=0 -> hold/set/reset, pol=1 -> lean on toggle.
// Ports:
//   cur  in  present flip-flop state
//   t    in  wanted next state
//   pol  in  don't-care policy
//   jk   out {j,k}
module jk_excite
  import jkseq_pkg::*;
(
  input  logic       cur,
  input  logic       t,
  input  logic       pol,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    unique case ({cur, t})
      2'b00:   jk = pol ? JK_RST : JK_HOLD;
      2'b01:   jk = pol ? JK_TGL : JK_SET;
      2'b10:   jk = pol ? JK_TGL : JK_RST;
      default: jk = pol ? JK_SET : JK_HOLD;
    endcase
  end

endmodule

// File: rtl/jk_stim_sequencer.sv
// Drives j/k to an external JK flip-flop so that its q walks through a
// LEN-step target pattern (bit 0 first), and checks q_fb against that
// pattern two edges after each step is driven.
// Ports:
//   c, rst_n     clock (rising) / async active-low reset
//   start        run request, honoured only in IDLE
//   pattern, pol target sequence and don't-care policy, latched on start
//   q_fb         flip-flop output
//   j, k         registered drive
//   busy, done   run in progress / one-cycle completion pulse
//   err          sticky mismatch flag, cleared on start
//   idx          step being driven (0 outside RUN)
//   mis_cnt      saturating mismatch count (only with JKSEQ_MISCNT_EN)
// Build option: define JKSEQ_MISCNT_EN to add the mis_cnt port and counter.
module jk_stim_sequencer
  import jkseq_pkg::*;
#(
  parameter  int LEN  = 8,
  parameter  int CNTW = 4,
  localparam int IDXW = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            start,
  input  logic [LEN-1:0]  pattern,
  input  logic            pol,
  input  logic            q_fb,
  output logic            j,
  output logic            k,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [IDXW-1:0] idx
`ifdef JKSEQ_MISCNT_EN
  ,
  output logic [CNTW-1:0] mis_cnt
`endif
);

  state_t          state, state_nxt;
  logic [LEN-1:0]  pat_r;
  logic            pol_r;
  logic            cur;        // expected flip-flop state, never taken from q_fb
  logic [IDXW-1:0] step;
  logic            drain_cnt;
  logic [1:0]      exp_pipe;   // expected q per driven step, 2 edges deep
  logic [1:0]      vld_pipe;

  logic            accept, last_step, drive;
  logic [IDXW-1:0] nxt_idx;
  logic            ex_cur, ex_t, ex_pol;
  logic [1:0]      jk_nx;

  assign accept    = (state == IDLE) && start;
  assign last_step = (step == IDXW'(LEN - 1));
  assign nxt_idx   = last_step ? '0 : step + IDXW'(1);
  // A step is driven on the accepting edge and on every RUN edge but the last.
  assign drive     = accept || ((state == RUN) && !last_step);

  // Step 0 is computed straight from the inputs so it can be registered on
  // the accepting edge; later steps come from the latched copies.
  assign ex_cur = (state == IDLE) ? q_fb       : cur;
  assign ex_t   = (state == IDLE) ? pattern[0] : pat_r[nxt_idx];
  assign ex_pol = (state == IDLE) ? pol        : pol_r;

  jk_excite u_excite (
    .cur (ex_cur),
    .t   (ex_t),
    .pol (ex_pol),
    .jk  (jk_nx)
  );

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)     state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign idx  = step;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      j         <= 1'b0;
      k         <= 1'b0;
      pat_r     <= '0;
      pol_r     <= 1'b0;
      cur       <= 1'b0;
      step      <= '0;
      drain_cnt <= 1'b0;
      exp_pipe  <= '0;
      vld_pipe  <= '0;
      err       <= 1'b0;
    end else begin
      {j, k}    <= drive ? jk_nx : JK_HOLD;
      vld_pipe  <= {vld_pipe[0], drive};
      exp_pipe  <= {exp_pipe[0], ex_t};
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      if (drive) cur <= ex_t;
      if (accept) begin
        pat_r <= pattern;
        pol_r <= pol;
      end
      if ((state == RUN) && !last_step) step <= step + IDXW'(1);
      else                              step <= '0;
      if (accept)                                 err <= 1'b0;
      else if (vld_pipe[1] && (q_fb != exp_pipe[1])) err <= 1'b1;
    end
  end

`ifdef JKSEQ_MISCNT_EN
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n)
      mis_cnt <= '0;
    else if (accept)
      mis_cnt <= '0;
    else if (vld_pipe[1] && (q_fb != exp_pipe[1]) && (mis_cnt != {CNTW{1'b1}}))
      mis_cnt <= mis_cnt + CNTW'(1);
  end
`endif

endmodule

// File: tb/tb_jk_stim_sequencer.sv
`timescale 1ns/1ps
module tb_jk_stim_sequencer;

  logic       c = 1'b0;
  logic       rst_n, start, pol, q_fb;
  logic [7:0] pattern;
  logic       j, k, busy, done, err;
  logic [2:0] idx;
  logic       stuck;
  int         errors = 0;
  int         checks = 0;
  logic [15:0] obs;

  always #5 c = ~c;

  jk_stim_sequencer #(.LEN(8), .CNTW(4)) u_dut (
    .c(c), .rst_n(rst_n), .start(start), .pattern(pattern), .pol(pol),
    .q_fb(q_fb), .j(j), .k(k), .busy(busy), .done(done), .err(err), .idx(idx)
`ifdef JKSEQ_MISCNT_EN
    , .mis_cnt(mis_cnt)
`endif
  );

`ifdef JKSEQ_MISCNT_EN
  logic [3:0] mis_cnt;
  logic [1:0] mis_cnt2;
  logic       j2, k2, busy2, done2, err2;
  logic [2:0] idx2;
  // Narrow counter instance sharing the same stimulus, for saturation.
  jk_stim_sequencer #(.LEN(8), .CNTW(2)) u_dut2 (
    .c(c), .rst_n(rst_n), .start(start), .pattern(pattern), .pol(pol),
    .q_fb(q_fb), .j(j2), .k(k2), .busy(busy2), .done(done2), .err(err2),
    .idx(idx2), .mis_cnt(mis_cnt2)
  );
`endif

  // Behavioural JK flip-flop, optionally stuck at 0.
  initial q_fb = 1'b0;
  always @(posedge c) begin
    if (stuck) q_fb <= 1'b0;
    else case ({j, k})
      2'b01:   q_fb <= 1'b0;
      2'b10:   q_fb <= 1'b1;
      2'b11:   q_fb <= ~q_fb;
      default: q_fb <= q_fb;
    endcase
  end

  // Excitation table: transition cur->t, pol picks the don't-care filler.
  function automatic logic [1:0] ref_jk(input logic cur, input logic t, input logic p);
    case ({cur, t})
      2'b00:   return p ? 2'b01 : 2'b00;
      2'b01:   return p ? 2'b11 : 2'b10;
      2'b10:   return p ? 2'b11 : 2'b01;
      default: return p ? 2'b10 : 2'b00;
    endcase
  endfunction

  // One full run starting at a negedge; checks every cycle from E0 to E0+11.
  task automatic drive_run(input logic [7:0] pat, input logic p, input logic stk,
                           input logic hold, output logic [15:0] seen);
    logic [1:0] ejk [8];
    logic       mism [8];
    logic       cq, eerr;
    int         nmis;
    logic [1:0] ojk, wjk;
    stuck = stk; start = 1'b1; pattern = pat; pol = p;
    cq = q_fb;
    for (int i = 0; i < 8; i++) begin
      ejk[i]  = ref_jk(cq, pat[i], p);
      mism[i] = stk && pat[i];
      cq      = pat[i];
    end
    seen = '0;
    for (int m = 0; m < 12; m++) begin
      @(negedge c);
      eerr = 1'b0; nmis = 0;
      for (int s = 0; s < 8; s++)
        if (s + 2 <= m && mism[s]) begin eerr = 1'b1; nmis++; end
      ojk = {j, k};
      wjk = (m < 8) ? ejk[m] : 2'b00;
      if (m < 8) seen[2*m +: 2] = ojk;
      checks++;
      if (ojk !== wjk) begin errors++; $display("FAIL jk m=%0d got %b want %b", m, ojk, wjk); end
      checks++;
      if (idx !== ((m < 8) ? 3'(m) : 3'd0)) begin errors++; $display("FAIL idx m=%0d got %0d", m, idx); end
      checks++;
      if (busy !== (m < 10)) begin errors++; $display("FAIL busy m=%0d got %b want %b", m, busy, m < 10); end
      checks++;
      if (done !== (m == 10)) begin errors++; $display("FAIL done m=%0d got %b want %b", m, done, m == 10); end
      checks++;
      if (err !== eerr) begin errors++; $display("FAIL err m=%0d got %b want %b", m, err, eerr); end
`ifdef JKSEQ_MISCNT_EN
      checks++;
      if (mis_cnt !== 4'((nmis > 15) ? 15 : nmis)) begin
        errors++; $display("FAIL mis_cnt m=%0d got %0d want %0d", m, mis_cnt, nmis);
      end
      checks++;
      if (mis_cnt2 !== 2'((nmis > 3) ? 3 : nmis)) begin
        errors++; $display("FAIL mis_cnt_sat m=%0d got %0d want %0d", m, mis_cnt2, (nmis > 3) ? 3 : nmis);
      end
`endif
      // Start pulses (or a held start) and input churn while busy must be ignored.
      start = (m == 11) ? hold : (hold ? 1'b1 : 1'($urandom_range(0, 1)));
      if (m < 11) begin pattern = 8'($urandom); pol = 1'($urandom); end
    end
  endtask

  task automatic clear_q();
    stuck = 1'b1;
    @(negedge c);
    stuck = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pattern = '0; pol = 1'b0; stuck = 1'b0;
    #12;
    checks++;
    if ({j, k, busy, done, err, idx} !== 8'd0) begin
      errors++; $display("FAIL reset_state got %b want 0", {j, k, busy, done, err, idx});
    end
    @(negedge c); rst_n = 1'b1;
    @(negedge c);
  endtask

  task automatic test_directed();
    clear_q();
    drive_run(8'b1011_0010, 1'b0, 1'b0, 1'b0, obs);
    checks++;
    if (obs !== 16'b10_01_00_10_00_01_10_00) begin
      errors++; $display("FAIL directed_pol0 got %b", obs);
    end
    clear_q();
    drive_run(8'b1011_0010, 1'b1, 1'b0, 1'b0, obs);
    checks++;
    if (obs !== 16'b11_11_10_11_01_11_11_01) begin
      errors++; $display("FAIL directed_pol1 got %b", obs);
    end
    checks++;
    if (q_fb !== 1'b1) begin errors++; $display("FAIL q_final got %b want 1", q_fb); end
  endtask

  task automatic test_stuck();
    drive_run(8'hFF, 1'b0, 1'b1, 1'b0, obs);
    drive_run(8'hFF, 1'b1, 1'b1, 1'b0, obs);
    stuck = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      drive_run(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0, obs);
    stuck = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_run(8'($urandom), 1'($urandom), 1'b0, 1'b1, obs);
    drive_run(8'($urandom), 1'($urandom), 1'b1, 1'b1, obs);
    drive_run(8'($urandom), 1'($urandom), 1'b0, 1'b0, obs);
  endtask

  task automatic test_reset_midrun();
    stuck = 1'b1; start = 1'b1; pattern = 8'hFF; pol = 1'b0;
    for (int m = 0; m < 5; m++) begin
      @(negedge c);
      start = 1'b0;
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || idx !== 3'd4) begin
      errors++; $display("FAIL pre_reset got err=%b busy=%b idx=%0d", err, busy, idx);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({j, k, busy, done, err, idx} !== 8'd0) begin
      errors++; $display("FAIL async_reset got %b want 0", {j, k, busy, done, err, idx});
    end
`ifdef JKSEQ_MISCNT_EN
    checks++;
    if (mis_cnt !== 4'd0) begin errors++; $display("FAIL reset_mis_cnt got %0d want 0", mis_cnt); end
`endif
    @(negedge c); rst_n = 1'b1; stuck = 1'b0;
    for (int m = 0; m < 14; m++) begin
      @(negedge c);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset m=%0d got done=%b busy=%b", m, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stuck();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
